store_unit: RTL and testbench
=============================

// Module: store_unit
//
// PURPOSE
//   Write-side counterpart to the load path. Formats SB/SH/SW data and byte enables for the 32-bit data memory.
//   Buffers stores in a small FIFO and drains them to dmem over a valid/ready handshake.
//   Sits between execute (store address/data from ALU and rs2) and the data memory write port.
//   Lets the pipeline retire stores without stalling on a slow memory.
//
// PARAMETERS
//   DEPTH   4   store buffer entries; power of 2, >= 2
//   AW      32  byte address width; dmem_addr is word-aligned (bits [1:0] forced 0)
//
// PORTS
//   clk           in   1   system clock, rising edge
//   rst_n         in   1   asynchronous active-low reset
//   st_valid      in   1   execute presents a store
//   st_ready      out  1   buffer can accept; handshake when st_valid && st_ready
//   st_funct3     in   2   funct3[1:0]: 00 SB, 01 SH, 10 SW, 11 treated as SW
//   st_addr       in   AW  byte address
//   st_data       in   32  rs2 value
//   dmem_we       out  1   head entry valid / write request
//   dmem_ready    in   1   memory accepts write this cycle
//   dmem_addr     out  AW  word address of head entry, [1:0]=0
//   dmem_din      out  32  lane-replicated write data
//   dmem_be       out  4   byte enables, bit i = byte lane i
//   buf_empty     out  1   no stores pending (fence/load-ordering use)
//   misalign_err  out  1   1-cycle pulse on a rejected misaligned store
//
// BEHAVIOUR
//   - Reset (async, rst_n=0): wr/rd pointers 0, count 0, dmem_we 0, buf_empty 1, misalign_err 0.
//   - While empty, dmem_addr/dmem_din/dmem_be drive 0. Reset mid-drain drops all entries.
//   - Lane formatting is done at enqueue and stored per entry:
//       SB: be = 4'b0001 << addr[1:0];        din = {4{data[7:0]}}
//       SH: be = 4'b0011 << {addr[1],1'b0};   din = {2{data[15:0]}}
//       SW: be = 4'b1111;                     din = data
//     entry addr = {st_addr[AW-1:2],2'b00}
//   - st_ready = (count != DEPTH), combinational from count only. It does not look ahead to a same-cycle pop.
//   - Push on st_valid && st_ready. Pop on dmem_we && dmem_ready.
//   - Push and pop in the same cycle: count unchanged, both pointers advance.
//   - dmem_we = (count != 0). Head fields stay stable until the pop.
//   - Latency: accept at edge N -> dmem_we=1 after edge N (earliest memory accept is cycle N+1). There is no bypass.
//   - Pointers are log2(DEPTH) bits and wrap naturally. A count register distinguishes full from empty.
//   - Drain order is strictly FIFO. Stores are never merged or coalesced.
//   - buf_empty = (count == 0).
//   - dmem_ready while dmem_we=0 has no effect.
//
// CONFIGURATION
//   STORE_MISALIGN_TRAP_EN defined:
//     - Misaligned = SH with addr[0]=1, or SW with addr[1:0]!=0.
//     - A misaligned store completes the handshake (st_ready unaffected) but is NOT enqueued.
//     - misalign_err is registered: high for exactly one cycle after the accepting edge.
//   STORE_MISALIGN_TRAP_EN undefined:
//     - Offending low address bits are ignored: SH uses addr[1] only, SW uses lane 0.
//     - Every accepted store is enqueued. misalign_err is tied 0.
//
// TESTING
//   1. Reset: rst_n=0 mid-drain with count=3 -> dmem_we=0, buf_empty=1, st_ready=1 immediately, without waiting for a clock.
//   2. Lanes: SB addr=0x103 data=0xAABBCCDD -> dmem_addr=0x100, be=4'b1000, din=0xDDDDDDDD.
//      SH addr=0x102 data=0x1234 -> be=4'b1100, din=0x12341234.
//      SW addr=0x200 -> be=4'b1111.
//   3. Full: hold dmem_ready=0 and push 4 stores -> st_ready=0 after the 4th accept.
//      Then pulse dmem_ready for 1 cycle -> one pop, st_ready=1 next cycle. Drain order matches push order.
//   4. Simultaneous: count=2, push and pop on the same edge -> count stays 2; next head is the 2nd-oldest store.
//   5. Wrap: stream 10 stores with dmem_ready=1 every other cycle -> all 10 written in order, no loss or duplication.
//   6. Misaligned SW addr=0x101 with STORE_MISALIGN_TRAP_EN -> accepted, misalign_err=1 for 1 cycle, buf_empty stays 1.
//      Without the macro -> written at 0x100 with be=4'b1111.

Source files
------------

// File: rtl/store_unit.sv
// store_unit: formats SB/SH/SW lanes, buffers stores in a FIFO and drains them to dmem.
// Define STORE_MISALIGN_TRAP_EN to reject misaligned SH/SW with a one-cycle misalign_err pulse.
module store_unit #(
  parameter int DEPTH = 4,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [1:0]    st_funct3,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  output logic          dmem_we,
  input  logic          dmem_ready,
  output logic [AW-1:0] dmem_addr,
  output logic [31:0]   dmem_din,
  output logic [3:0]    dmem_be,
  output logic          buf_empty,
  output logic          misalign_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] ent_addr_q [DEPTH];
  logic [31:0]   ent_din_q [DEPTH];
  logic [3:0]    ent_be_q [DEPTH];
  logic [AW-1:0] ent_addr_d;
  logic [31:0]   ent_din_d;
  logic [3:0]    ent_be_d;
  logic          acc, push, pop;
  always_comb begin
    ent_addr_d = {st_addr[AW-1:2], 2'b00};
    ent_be_d   = st_funct3[1] ? 4'b1111 :
                 st_funct3[0] ? 4'b0011 << {st_addr[1], 1'b0} : 4'b0001 << st_addr[1:0];
    ent_din_d  = st_funct3[1] ? st_data :
                 st_funct3[0] ? {2{st_data[15:0]}} : {4{st_data[7:0]}};
  end
  assign st_ready  = count_q != CW'(DEPTH);
  assign dmem_we   = count_q != '0;
  assign buf_empty = !dmem_we;
  assign acc       = st_valid && st_ready;
  assign pop       = dmem_we && dmem_ready;
  assign dmem_addr = dmem_we ? ent_addr_q[rd_q] : '0;
  assign dmem_din  = dmem_we ? ent_din_q[rd_q] : '0;
  assign dmem_be   = dmem_we ? ent_be_q[rd_q] : '0;
`ifdef STORE_MISALIGN_TRAP_EN
  logic mis, err_q, err_d;
  always_comb begin
    mis   = st_funct3[1] ? |st_addr[1:0] : st_funct3[0] & st_addr[0];
    push  = acc && !mis;
    err_d = acc && mis;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else err_q <= err_d;
  assign misalign_err = err_q;
`else
  assign push = acc;
  assign misalign_err = 1'b0;
`endif
  always_comb begin
    wr_d    = push ? wr_q + PW'(1) : wr_q;
    rd_d    = pop ? rd_q + PW'(1) : rd_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
  // Entry storage needs no reset: outputs are masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr_q[wr_q] <= ent_addr_d;
      ent_din_q[wr_q]  <= ent_din_d;
      ent_be_q[wr_q]   <= ent_be_d;
    end
  end
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed tests of lane formatting, full/empty, simultaneous push/pop, wrap and misalignment.
module tb_store_unit;
  logic        clk = 0, rst_n = 0;
  logic        st_valid = 0, st_ready, dmem_we, dmem_ready = 0, buf_empty, misalign_err;
  logic [1:0]  st_funct3 = 0;
  logic [31:0] st_addr = 0, st_data = 0, dmem_addr, dmem_din;
  logic [3:0]  dmem_be;
  int total = 0, bad = 0;

  store_unit #(.DEPTH(4), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_funct3(st_funct3), .st_addr(st_addr), .st_data(st_data),
    .dmem_we(dmem_we), .dmem_ready(dmem_ready), .dmem_addr(dmem_addr),
    .dmem_din(dmem_din), .dmem_be(dmem_be), .buf_empty(buf_empty),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic do_store(input logic [1:0] f, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    st_valid = 1; st_funct3 = f; st_addr = a; st_data = d;
    @(posedge clk); #1;
    st_valid = 0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    dmem_ready = 1;
    @(posedge clk); #1;
    dmem_ready = 0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (dmem_we !== 1'b0 || buf_empty !== 1'b1 || st_ready !== 1'b1 || misalign_err !== 1'b0) begin
      bad++; $display("FAIL reset_init: we=%b empty=%b rdy=%b err=%b want 0 1 1 0", dmem_we, buf_empty, st_ready, misalign_err); end
    @(negedge clk); rst_n = 1;
    do_store(2'b10, 32'h40, 32'h1); do_store(2'b10, 32'h44, 32'h2); do_store(2'b10, 32'h48, 32'h3);
    @(negedge clk); dmem_ready = 1; #1;
    rst_n = 0; #1;
    total++; if (dmem_we !== 1'b0 || buf_empty !== 1'b1 || st_ready !== 1'b1 || dmem_addr !== 32'h0) begin
      bad++; $display("FAIL reset_mid: we=%b empty=%b rdy=%b addr=%h want 0 1 1 0", dmem_we, buf_empty, st_ready, dmem_addr); end
    dmem_ready = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    total++; if (buf_empty !== 1'b1) begin bad++; $display("FAIL reset_release: empty=%b want 1", buf_empty); end
  endtask

  task automatic test_lanes();
    do_store(2'b00, 32'h103, 32'hAABBCCDD);
    total++; if (dmem_we !== 1'b1 || dmem_addr !== 32'h100 || dmem_be !== 4'b1000 || dmem_din !== 32'hDDDDDDDD) begin
      bad++; $display("FAIL lane_sb: we=%b addr=%h be=%b din=%h want 1 100 1000 dddddddd", dmem_we, dmem_addr, dmem_be, dmem_din); end
    pop_one();
    do_store(2'b01, 32'h102, 32'h00001234);
    total++; if (dmem_addr !== 32'h100 || dmem_be !== 4'b1100 || dmem_din !== 32'h12341234) begin
      bad++; $display("FAIL lane_sh: addr=%h be=%b din=%h want 100 1100 12341234", dmem_addr, dmem_be, dmem_din); end
    pop_one();
    do_store(2'b10, 32'h200, 32'hCAFEF00D);
    total++; if (dmem_addr !== 32'h200 || dmem_be !== 4'b1111 || dmem_din !== 32'hCAFEF00D) begin
      bad++; $display("FAIL lane_sw: addr=%h be=%b din=%h want 200 1111 cafef00d", dmem_addr, dmem_be, dmem_din); end
    pop_one();
    do_store(2'b11, 32'h204, 32'h01020304);
    total++; if (dmem_be !== 4'b1111 || dmem_din !== 32'h01020304) begin
      bad++; $display("FAIL lane_f11: be=%b din=%h want 1111 01020304", dmem_be, dmem_din); end
    pop_one();
    total++; if (buf_empty !== 1'b1 || dmem_be !== 4'b0000 || dmem_din !== 32'h0) begin
      bad++; $display("FAIL lane_empty: empty=%b be=%b din=%h want 1 0000 0", buf_empty, dmem_be, dmem_din); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL full_ready%0d: rdy=%b want 1", i, st_ready); end
      do_store(2'b10, 32'h10 + 32'(4 * i), 32'(i + 1));
    end
    total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL full_notready: rdy=%b want 0", st_ready); end
    total++; if (dmem_addr !== 32'h10) begin bad++; $display("FAIL full_head: addr=%h want 10", dmem_addr); end
    pop_one();
    total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL full_reopen: rdy=%b want 1", st_ready); end
    for (int i = 1; i < 4; i++) begin
      total++; if (dmem_addr !== 32'h10 + 32'(4 * i) || dmem_din !== 32'(i + 1)) begin
        bad++; $display("FAIL full_order%0d: addr=%h din=%h want %h %h", i, dmem_addr, dmem_din, 32'h10 + 32'(4 * i), i + 1); end
      pop_one();
    end
    total++; if (buf_empty !== 1'b1) begin bad++; $display("FAIL full_drained: empty=%b want 1", buf_empty); end
  endtask

  task automatic test_simul();
    do_store(2'b10, 32'hA0, 32'hA);
    do_store(2'b10, 32'hA4, 32'hB);
    @(negedge clk);
    st_valid = 1; st_funct3 = 2'b10; st_addr = 32'hA8; st_data = 32'hC; dmem_ready = 1;
    @(posedge clk); #1;
    st_valid = 0; dmem_ready = 0;
    total++; if (dmem_addr !== 32'hA4) begin bad++; $display("FAIL simul_head: addr=%h want a4", dmem_addr); end
    pop_one();
    total++; if (buf_empty !== 1'b0 || dmem_addr !== 32'hA8) begin
      bad++; $display("FAIL simul_second: empty=%b addr=%h want 0 a8", buf_empty, dmem_addr); end
    pop_one();
    total++; if (buf_empty !== 1'b1) begin bad++; $display("FAIL simul_count: empty=%b want 1", buf_empty); end
  endtask

  task automatic test_wrap();
    int pushed = 0, popped = 0, cyc = 0, errs = 0;
    while (popped < 10 && cyc < 200) begin
      @(negedge clk);
      dmem_ready = cyc[0];
      if (st_ready && pushed < 10) begin
        st_valid = 1; st_funct3 = 2'b10; st_addr = 32'h300 + 32'(4 * pushed); st_data = 32'(pushed) * 32'h11111111;
        pushed++;
      end else st_valid = 0;
      #1;
      if (dmem_we && dmem_ready) begin
        if (dmem_addr !== 32'h300 + 32'(4 * popped) || dmem_din !== 32'(popped) * 32'h11111111) begin
          errs++; $display("FAIL wrap_item%0d: addr=%h din=%h want %h %h", popped, dmem_addr, dmem_din,
                           32'h300 + 32'(4 * popped), 32'(popped) * 32'h11111111); end
        popped++;
      end
      cyc++;
    end
    @(negedge clk); st_valid = 0; dmem_ready = 0;
    total++; if (errs != 0) bad++;
    total++; if (popped != 10 || buf_empty !== 1'b1) begin
      bad++; $display("FAIL wrap_count: popped=%0d empty=%b want 10 1", popped, buf_empty); end
  endtask

  task automatic test_misalign();
    do_store(2'b10, 32'h101, 32'h55667788);
`ifdef STORE_MISALIGN_TRAP_EN
    total++; if (misalign_err !== 1'b1 || buf_empty !== 1'b1) begin
      bad++; $display("FAIL mis_trap: err=%b empty=%b want 1 1", misalign_err, buf_empty); end
    @(posedge clk); #1;
    total++; if (misalign_err !== 1'b0 || buf_empty !== 1'b1) begin
      bad++; $display("FAIL mis_pulse: err=%b empty=%b want 0 1", misalign_err, buf_empty); end
`else
    total++; if (dmem_addr !== 32'h100 || dmem_be !== 4'b1111 || dmem_din !== 32'h55667788 || misalign_err !== 1'b0) begin
      bad++; $display("FAIL mis_pass: addr=%h be=%b din=%h err=%b want 100 1111 55667788 0", dmem_addr, dmem_be, dmem_din, misalign_err); end
    pop_one();
    do_store(2'b01, 32'h107, 32'h0000BEEF);
    total++; if (dmem_addr !== 32'h104 || dmem_be !== 4'b1100 || dmem_din !== 32'hBEEFBEEF) begin
      bad++; $display("FAIL mis_sh: addr=%h be=%b din=%h want 104 1100 beefbeef", dmem_addr, dmem_be, dmem_din); end
    pop_one();
`endif
  endtask

  initial begin
    test_reset();
    test_lanes();
    test_full();
    test_simul();
    test_wrap();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
